// File: rtl/serial_cmp_ctrl_pkg.sv
// Shared definitions for the sequential pair-at-a-time magnitude comparator.
// State encodings plus the operand-width legality check used at elaboration.
package serial_cmp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operands are walked two bits at a time, so the width must split into pairs.
  function automatic bit width_ok(input int w);
    return (w >= 2) && ((w % 2) == 0);
  endfunction

endpackage

// File: rtl/serial_cmp_ctrl_cmp2.sv
// Combinational 2-bit magnitude slice; the controller feeds it one operand pair per cycle.
module cmp2_slice (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       gt,
  output logic       eq
);

  assign gt = (x > y);
  assign eq = (x == y);

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Multi-cycle unsigned comparator: scans operand pairs MSB-first through one
// 2-bit slice and stops at the first pair that differs.
module serial_cmp_ctrl
  import serial_cmp_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH / 2) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             M,
  output logic             I,
  output logic [CW-1:0]    used
);

  localparam int NPAIRS = WIDTH / 2;

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("serial_cmp_ctrl: WIDTH must be even and >= 2");
  end

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [CW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [1:0]       pair_a;
  logic [1:0]       pair_b;
  logic             sm;
  logic             si;

  // Pair select: idx never exceeds NPAIRS-1 while in RUN.
  always_comb begin
    pair_a = 2'b00;
    pair_b = 2'b00;
    for (int p = 0; p < NPAIRS; p++) begin
      if (idx == CW'(p)) begin
        pair_a = ra[2*p +: 2];
        pair_b = rb[2*p +: 2];
      end
    end
  end

  cmp2_slice u_slice (
    .x  (pair_a),
    .y  (pair_b),
    .gt (sm),
    .eq (si)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      ra    <= '0;
      rb    <= '0;
      idx   <= '0;
      cnt   <= '0;
      M     <= 1'b0;
      I     <= 1'b0;
      used  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            idx   <= CW'(NPAIRS - 1);
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!si) begin
            M     <= sm;
            I     <= 1'b0;
            used  <= cnt + CW'(1);
            state <= ST_DONE;
          end else if (idx == '0) begin
            M     <= 1'b0;
            I     <= 1'b1;
            used  <= CW'(NPAIRS);
            state <= ST_DONE;
          end else begin
            idx <= idx - CW'(1);
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Scoreboard bench for serial_cmp_ctrl (WIDTH=8): driver pushes model results,
// a negedge monitor pops and checks them whenever done is seen.
module tb_serial_cmp_ctrl;

  localparam int WIDTH  = 8;
  localparam int NPAIRS = WIDTH / 2;
  localparam int CW     = $clog2(NPAIRS) + 1;

  typedef struct {
    bit m;
    bit i;
    int used;
    int acc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic             M;
  logic             I;
  logic [CW-1:0]    used;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];

  serial_cmp_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .M     (M),
    .I     (I),
    .used  (used)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: unsigned compare, and pairs scanned MSB-first until one differs.
  function automatic exp_t model(input int av, input int bv, input int acc);
    exp_t e;
    e.m = (av > bv);
    e.i = (av == bv);
    e.used = 0;
    for (int p = NPAIRS - 1; p >= 0; p--) begin
      e.used++;
      if (((av >> (2 * p)) & 3) != ((bv >> (2 * p)) & 3)) break;
    end
    e.acc = acc;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("op done: M=%0d I=%0d used=%0d cycle=%0d", M, I, used, cyc);
        check("result_M", int'(M), int'(e.m));
        check("result_I", int'(I), int'(e.i));
        check("result_used", int'(used), e.used);
        check("done_latency", cyc - e.acc, e.used);
        check("busy_at_done", int'(busy), 1);
      end
    end
  end

  // Wait until the monitor has drained the scoreboard; optionally drop start then.
  task automatic wait_drain(input bit drop_start);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got %0d pending ops expected 0", sb.size());
      sb.delete();
    end
    if (drop_start) start = 1'b0;
    @(negedge clk);
    #1;
    check("busy_idle_after", int'(busy), 0);
  endtask

  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    @(negedge clk);
    start = 1'b1;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back(model(int'(av), int'(bv), cyc));
  endtask

  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    issue(av, bv);
    wait_drain(1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra_v, rb_v;

    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_M", int'(M), 0);
    check("reset_I", int'(I), 0);
    check("reset_used", int'(used), 0);
    rst = 1'b0;

    run_op(8'hA5, 8'hA5);
    run_op(8'hC0, 8'h80);
    run_op(8'h12, 8'h13);

    // start and operand changes during RUN must be ignored
    issue(8'h01, 8'h02);
    @(negedge clk);
    start = 1'b1;
    a = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_drain(1'b0);

    // Asynchronous abort in the middle of a compare
    issue(8'h00, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_M", int'(M), 0);
    check("abort_I", int'(I), 0);
    check("abort_used", int'(used), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h40, 8'h3F);

    // start held high: one acceptance every 3 cycles
    @(negedge clk);
    a = 8'h7F;
    b = 8'h80;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) sb.push_back(model(32'h7F, 32'h80, cyc + 3 * k));
    wait_drain(1'b1);

    for (int t = 0; t < 60; t++) begin
      ra_v = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb_v = ra_v;
        1:       rb_v = ra_v ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        default: rb_v = WIDTH'($urandom);
      endcase
      run_op(ra_v, rb_v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
